muxn_rr_reg: RTL and testbench

- Parametrised N-input, WIDTH-bit selector; next generation of the 2:1 selector used in the datapath.
- Adds a registered output stage with valid/ready handshake and two selection modes:
  - fixed (external select)
  - round-robin (fair arbitration among requesting inputs)
- Sits between producer channels (e.g. adder/multiplier result streams) and a single shared consumer.

---
 rtl/muxn_pkg.sv | 13 +
 rtl/rr_pick.sv | 41 ++++
 rtl/muxn_rr_reg.sv | 103 ++++++++++
 tb/tb_muxn_rr_reg.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared definitions for the N-input registered selector.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   next_idx             : modulo-n increment used for the round-robin pointer
package muxn_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, wrapping.
//   req       : per-channel request vector
//   ptr       : highest-priority index this cycle (must be < N)
//   gnt_valid : some request asserted
//   gnt_idx   : index of the winning request
module rr_pick #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic [N-1:0] w_rot;
  int           w_pos;

  // Modulo-N add of two indices that are each < N.
  function automatic int wrap_add(input int a, input int b);
    return (a + b >= N) ? a + b - N : a + b;
  endfunction

  // Rotate so that ptr lands on bit 0.
  always_comb begin
    w_rot = '0;
    for (int j = 0; j < N; j++)
      w_rot[j] = req[wrap_add(j, int'(ptr))];
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    w_pos = 0;
    for (int j = N - 1; j >= 0; j--)
      if (w_rot[j]) w_pos = j;
  end

  assign gnt_valid = |req;
  assign gnt_idx   = SELW'(wrap_add(w_pos, int'(ptr)));

endmodule

// File: rtl/muxn_rr_reg.sv
// N-input WIDTH-bit selector with a registered valid/ready output stage.
//   clk, reset          : clock, synchronous active-high reset
//   mode, sel           : 0 = fixed channel sel, 1 = round-robin
//   in_valid/in_data    : producer channels (channel i at [i*WIDTH +: WIDTH])
//   in_ready            : combinational accept, at most one bit high
//   out_valid/out_data  : registered output word
//   out_chan            : channel that supplied out_data
//   out_ready           : consumer accepts out_data
module muxn_rr_reg
  import muxn_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  input  logic               out_ready
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic [SELW-1:0]   r_out_chan;
  logic [SELW-1:0]   r_ptr;

  logic              w_slot_free;
  logic              w_gnt_valid;
  logic [SELW-1:0]   w_gnt_idx;
  logic              w_acc;
  logic [WIDTH-1:0]  w_acc_data;
  logic [SELW-1:0]   w_acc_idx;

  rr_pick #(.N(N)) u_pick (
    .req       (in_valid),
    .ptr       (r_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_slot_free = !r_out_valid || out_ready;

  // Ready is held low while in reset so nothing looks accepted then.
  // The compare loop also makes an out-of-range sel (N not a power of 2)
  // assert nothing.
  always_comb begin
    in_ready = '0;
    if (!reset && w_slot_free) begin
      for (int i = 0; i < N; i++) begin
        if (mode == MODE_FIXED) begin
          if (SELW'(i) == sel) in_ready[i] = 1'b1;
        end else begin
          if (w_gnt_valid && SELW'(i) == w_gnt_idx) in_ready[i] = 1'b1;
        end
      end
    end
  end

  assign w_acc = |(in_valid & in_ready);

  // in_ready is one-hot, so it doubles as the data-mux select.
  always_comb begin
    w_acc_data = '0;
    w_acc_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (in_ready[i]) begin
        w_acc_data = in_data[i*WIDTH +: WIDTH];
        w_acc_idx  = SELW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_acc) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_acc_data;
        r_out_chan  <= w_acc_idx;
        if (mode == MODE_RR)
          r_ptr <= SELW'(next_idx(int'(w_acc_idx), N));
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_muxn_rr_reg.sv
module tb_muxn_rr_reg;

  logic        clk = 1'b0;
  logic        reset;

  // Instance A: N = 4
  logic        modeA;
  logic [1:0]  selA;
  logic [3:0]  vA;
  logic [31:0] dA;
  logic [3:0]  irA;
  logic        ovA;
  logic [7:0]  odA;
  logic [1:0]  ocA;
  logic        rdyA;

  // Instance B: N = 3
  logic        modeB;
  logic [1:0]  selB;
  logic [2:0]  vB;
  logic [23:0] dB;
  logic [2:0]  irB;
  logic        ovB;
  logic [7:0]  odB;
  logic [1:0]  ocB;
  logic        rdyB;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  muxn_rr_reg #(.WIDTH(8), .N(4)) dutA (
    .clk(clk), .reset(reset), .mode(modeA), .sel(selA),
    .in_valid(vA), .in_data(dA), .in_ready(irA),
    .out_valid(ovA), .out_data(odA), .out_chan(ocA), .out_ready(rdyA)
  );

  muxn_rr_reg #(.WIDTH(8), .N(3)) dutB (
    .clk(clk), .reset(reset), .mode(modeB), .sel(selB),
    .in_valid(vB), .in_data(dB), .in_ready(irB),
    .out_valid(ovB), .out_data(odB), .out_chan(ocB), .out_ready(rdyB)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per-instance state: [0] = A (N=4), [1] = B (N=3)
  bit       m_ov [2];
  bit [7:0] m_od [2];
  int       m_oc [2];
  int       m_ptr[2];

  // Which channel may be accepted this cycle, straight from the rules.
  function automatic logic [3:0] exp_ready(input int n, input logic m, input int s,
      input logic [3:0] v, input bit ov, input logic ordy, input int p, input logic rst);
    if (rst || (ov && !ordy)) return 4'b0;
    if (m == 1'b0) return (s < n) ? (4'b1 << s) : 4'b0;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = (p + k) % n;
      if (v[idx]) return 4'b1 << idx;
    end
    return 4'b0;
  endfunction

  function automatic logic [3:0] rdy_of(input int u);
    if (u == 0) return exp_ready(4, modeA, int'(selA), vA, m_ov[0], rdyA, m_ptr[0], reset);
    return exp_ready(3, modeB, int'(selB), {1'b0, vB}, m_ov[1], rdyB, m_ptr[1], reset);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      logic [3:0]  acc;
      logic [31:0] dat;
      logic        m, ordy;
      int          n;
      n    = (u == 0) ? 4 : 3;
      m    = (u == 0) ? modeA : modeB;
      ordy = (u == 0) ? rdyA : rdyB;
      dat  = (u == 0) ? dA : {8'h00, dB};
      acc  = rdy_of(u) & ((u == 0) ? vA : {1'b0, vB});
      if (reset) begin
        m_ov[u] = 0; m_od[u] = 8'h00; m_oc[u] = 0; m_ptr[u] = 0;
      end else if (acc != 4'b0) begin
        for (int k = 0; k < n; k++) begin
          if (acc[k]) begin
            m_ov[u] = 1; m_od[u] = dat[k*8 +: 8]; m_oc[u] = k;
            if (m) m_ptr[u] = (k + 1) % n;
          end
        end
      end else if (m_ov[u] && ordy) begin
        m_ov[u] = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("A_in_ready",  int'(irA), int'(rdy_of(0)));
      chk("A_out_valid", int'(ovA), int'(m_ov[0]));
      chk("A_out_data",  int'(odA), int'(m_od[0]));
      chk("A_out_chan",  int'(ocA), m_oc[0]);
      chk("B_in_ready",  int'(irB), int'(rdy_of(1)));
      chk("B_out_valid", int'(ovB), int'(m_ov[1]));
      chk("B_out_data",  int'(odB), int'(m_od[1]));
      chk("B_out_chan",  int'(ocB), m_oc[1]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    reset = 1; modeA = 1; selA = 0; vA = 4'hF; dA = 32'h44332211; rdyA = 1;
    modeB = 0; selB = 0; vB = 3'b000; dB = 24'h000000; rdyB = 1;

    // Reset for two cycles with every channel valid
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_ov",   int'(ovA), 0);
    chk("rst_od",   int'(odA), 0);
    chk("rst_oc",   int'(ocA), 0);
    chk("rst_irdy", int'(irA), 0);

    // Round-robin fairness: 0,1,2,3,0,1,2,3 back-to-back
    reset = 0;
    #1;
    chk("rr_first_rdy", int'(irA), 4'b0001);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_seq_chan",  int'(ocA), i % 4);
      chk("rr_seq_data",  int'(odA), 8'h11 * ((i % 4) + 1));
      chk("rr_seq_valid", int'(ovA), 1);
    end

    // Fixed mode, sel = 2
    modeA = 0; selA = 2; dA = 32'h44A52211;
    #1;
    chk("fix_rdy", int'(irA), 4'b0100);
    cyc();
    chk("fix_data", int'(odA), 8'hA5);
    chk("fix_chan", int'(ocA), 2);
    cyc();
    chk("fix_chan2", int'(ocA), 2);
    chk("fix_valid2", int'(ovA), 1);

    // Sparse round-robin with wrap: drive ptr to 3, then only ch0/ch1 request
    modeA = 1; vA = 4'b0100;
    cyc();
    chk("sp_ch2", int'(ocA), 2);
    vA = 4'b0011;
    cyc();
    chk("sp_w0", int'(ocA), 0);
    cyc();
    chk("sp_w1", int'(ocA), 1);
    cyc();
    chk("sp_w0b", int'(ocA), 0);

    // Backpressure: three stalled cycles, then drain + reload in one edge
    vA = 4'hF; rdyA = 0; dA = 32'h99887766;
    #1;
    chk("bp_rdy0", int'(irA), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_chan", int'(ocA), 0);
      chk("bp_hold_data", int'(odA), 8'h11);
      chk("bp_hold_rdy",  int'(irA), 0);
    end
    rdyA = 1;
    #1;
    chk("bp_release_rdy", int'(irA), 4'b0010);
    cyc();
    chk("bp_reload_chan", int'(ocA), 1);
    chk("bp_reload_data", int'(odA), 8'h77);

    // N = 3, fixed mode, out-of-range sel = 3
    selB = 1; vB = 3'b111; dB = 24'hCCBBAA; rdyB = 0;
    cyc();
    chk("n3_load_valid", int'(ovB), 1);
    chk("n3_load_data",  int'(odB), 8'hBB);
    selB = 3;
    #1;
    chk("n3_sel3_stall_rdy", int'(irB), 0);
    rdyB = 1;
    #1;
    chk("n3_sel3_rdy", int'(irB), 0);
    cyc();
    chk("n3_drain_valid", int'(ovB), 0);
    chk("n3_drain_chan",  int'(ocB), 1);
    cyc();
    chk("n3_idle_valid", int'(ovB), 0);

    // Reset while a word is held under backpressure
    rdyA = 0;
    cyc();
    chk("rm_hold_valid", int'(ovA), 1);
    reset = 1;
    cyc();
    chk("rm_valid", int'(ovA), 0);
    chk("rm_rdy",   int'(irA), 0);
    reset = 0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
